// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE,
        IMEM_WAIT,
        IMEM_RESP
    } imem_state_e;

    localparam logic [31:0] IMEM_ERR_DATA = 32'h0;

endpackage

// File: rtl/imem_array.sv
// Word storage for the fetch responder: synchronous write, combinational read.
module imem_array #(
    parameter int WORDS = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] widx,
    input  logic [31:0]              wdata,
    input  logic [$clog2(WORDS)-1:0] ridx,
    output logic [31:0]              rdata
);

    logic [31:0] mem [WORDS];

    // No reset: program words survive a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/imem_responder.sv
// Fetch-port responder: one request in flight, fixed latency, held response.
module imem_responder
    import imem_pkg::*;
#(
    parameter int WORDS   = 64,
    parameter int LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_err,
    input  logic                     ld_we,
    input  logic [$clog2(WORDS)-1:0] ld_idx,
    input  logic [31:0]              ld_data,
    output logic                     busy
);

    localparam int IW = $clog2(WORDS);
    localparam int CW = $clog2(LATENCY + 1);

    imem_state_e state;
    imem_state_e state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [31:0]   addr_q;
    logic [31:0]   cap_addr;
    logic [IW-1:0] rd_idx;
    logic [31:0]   rd_data;
    logic          cap_err;
    logic          cap;
    logic          accept;

    assign accept    = (state == IMEM_IDLE) && req_valid;
    assign req_ready = (state == IMEM_IDLE);
    assign busy      = (state != IMEM_IDLE);

    // With LATENCY=1 the capture happens on the accept edge itself.
    assign cap_addr = (state == IMEM_IDLE) ? req_addr : addr_q;
    assign rd_idx   = cap_addr[IW+1:2];
    assign cap_err  = (cap_addr[1:0] != 2'b00) ||
                      (cap_addr[31:IW+2] != '0);

    imem_array #(
        .WORDS(WORDS)
    ) u_array (
        .clk  (clk),
        .we   (ld_we),
        .widx (ld_idx),
        .wdata(ld_data),
        .ridx (rd_idx),
        .rdata(rd_data)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        cap      = 1'b0;
        unique case (state)
            IMEM_IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nx = IMEM_RESP;
                        cap      = 1'b1;
                    end else begin
                        state_nx = IMEM_WAIT;
                        cnt_nx   = CW'(LATENCY - 1);
                    end
                end
            end
            IMEM_WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_nx = IMEM_RESP;
                    cnt_nx   = '0;
                    cap      = 1'b1;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            IMEM_RESP: begin
                if (rsp_ready) begin
                    state_nx = IMEM_IDLE;
                end
            end
            default: begin
                state_nx = IMEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IMEM_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                addr_q <= req_addr;
            end
            if (cap) begin
                rsp_valid <= 1'b1;
                rsp_err   <= cap_err;
                rsp_data  <= cap_err ? IMEM_ERR_DATA : rd_data;
            end else if (state == IMEM_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: LATENCY=2 and LATENCY=1 builds.
module tb_imem_responder;

    localparam int WORDS = 64;
    localparam int IW    = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          rsp_ready;
    logic          ld_we;
    logic [IW-1:0] ld_idx;
    logic [31:0]   ld_data;

    logic          req_valid, req_ready, rsp_valid, rsp_err, busy;
    logic [31:0]   req_addr, rsp_data;

    logic          req_valid_b, req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
    logic [31:0]   req_addr_b, rsp_data_b;

    imem_responder #(.WORDS(WORDS), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data),
        .busy(busy)
    );

    imem_responder #(.WORDS(WORDS), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data_b), .rsp_err(rsp_err_b),
        .ld_we(ld_we), .ld_idx(ld_idx), .ld_data(ld_data),
        .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [10];

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [IW-1:0] idx, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_idx  = idx;
        ld_data = data;
        step();
        ld_we = 1'b0;
    endtask

    task automatic fetch(input string name, input logic [31:0] addr,
                         input logic [31:0] exp_d, input logic exp_e);
        check1({name, " req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        check1({name, " wait valid"}, rsp_valid, 1'b0);
        check1({name, " wait busy"}, busy, 1'b1);
        step();
        check1({name, " rsp_valid"}, rsp_valid, 1'b1);
        check32({name, " rsp_data"}, rsp_data, exp_d);
        check1({name, " rsp_err"}, rsp_err, exp_e);
        step();
        check1({name, " done valid"}, rsp_valid, 1'b0);
        check1({name, " done ready"}, req_ready, 1'b1);
    endtask

    initial begin
        vecs[0] = '{32'd0,         32'h00400a63, 1'b0};
        vecs[1] = '{32'd20,        32'h00400463, 1'b0};
        vecs[2] = '{32'd4,         32'h00000863, 1'b0};
        vecs[3] = '{32'd24,        32'h00000013, 1'b0};
        vecs[4] = '{32'd252,       32'hdeadbeef, 1'b0};
        vecs[5] = '{32'd6,         32'h00000000, 1'b1};
        vecs[6] = '{32'd256,       32'h00000000, 1'b1};
        vecs[7] = '{32'd1,         32'h00000000, 1'b1};
        vecs[8] = '{32'h80000000,  32'h00000000, 1'b1};
        vecs[9] = '{32'h00000103,  32'h00000000, 1'b1};

        rst         = 1'b1;
        rsp_ready   = 1'b1;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_valid_b = 1'b0;
        req_addr_b  = '0;
        ld_we       = 1'b0;
        ld_idx      = '0;
        ld_data     = '0;

        step();
        step();
        load(6'd0, 32'h00400a63);
        check1("reset req_ready", req_ready, 1'b1);
        check1("reset rsp_valid", rsp_valid, 1'b0);
        check32("reset rsp_data", rsp_data, 32'h0);
        check1("reset rsp_err", rsp_err, 1'b0);
        check1("reset busy", busy, 1'b0);
        check1("reset busy_b", busy_b, 1'b0);
        rst = 1'b0;

        load(6'd5, 32'h00400463);
        load(6'd1, 32'h00000863);
        load(6'd6, 32'h00000013);
        load(6'd63, 32'hdeadbeef);

        for (int i = 0; i < 10; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err);
        end

        // Backpressure: response held while rsp_ready is low.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'd4;
        step();
        req_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'd0;
            check1($sformatf("bp%0d valid", i), rsp_valid, 1'b1);
            check32($sformatf("bp%0d data", i), rsp_data, 32'h00000863);
            check1($sformatf("bp%0d req_ready", i), req_ready, 1'b0);
            check1($sformatf("bp%0d busy", i), busy, 1'b1);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        check1("bp end valid", rsp_valid, 1'b0);
        check1("bp end req_ready", req_ready, 1'b1);
        check1("bp end busy", busy, 1'b0);

        // Write landing before the capture edge is visible.
        ld_we     = 1'b1;
        ld_idx    = 6'd6;
        ld_data   = 32'hfe0004e3;
        req_valid = 1'b1;
        req_addr  = 32'd24;
        step();
        ld_we     = 1'b0;
        req_valid = 1'b0;
        step();
        check32("race new data", rsp_data, 32'hfe0004e3);
        step();

        // Write on the capture edge returns the old word.
        req_valid = 1'b1;
        req_addr  = 32'd24;
        step();
        req_valid = 1'b0;
        ld_we     = 1'b1;
        ld_idx    = 6'd6;
        ld_data   = 32'h11111111;
        step();
        ld_we = 1'b0;
        check1("race old valid", rsp_valid, 1'b1);
        check32("race old data", rsp_data, 32'hfe0004e3);
        step();
        fetch("race after", 32'd24, 32'h11111111, 1'b0);

        // Reset in WAIT aborts the fetch; load port still writes.
        req_valid = 1'b1;
        req_addr  = 32'd20;
        step();
        req_valid = 1'b0;
        check1("rstmid busy", busy, 1'b1);
        rst     = 1'b1;
        ld_we   = 1'b1;
        ld_idx  = 6'd7;
        ld_data = 32'h12345678;
        step();
        ld_we = 1'b0;
        rst   = 1'b0;
        check1("rstmid valid", rsp_valid, 1'b0);
        check1("rstmid req_ready", req_ready, 1'b1);
        check1("rstmid busy idle", busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check1($sformatf("rstmid quiet%0d", i), rsp_valid, 1'b0);
        end
        fetch("rstmid keep", 32'd20, 32'h00400463, 1'b0);
        fetch("rstmid ld", 32'd28, 32'h12345678, 1'b0);

        // LATENCY=1: response right after accept, spacing of two cycles.
        check1("l1 req_ready", req_ready_b, 1'b1);
        req_valid_b = 1'b1;
        req_addr_b  = 32'd20;
        step();
        check1("l1 valid0", rsp_valid_b, 1'b1);
        check32("l1 data0", rsp_data_b, 32'h00400463);
        check1("l1 err0", rsp_err_b, 1'b0);
        check1("l1 ready0", req_ready_b, 1'b0);
        check1("l1 busy0", busy_b, 1'b1);
        step();
        check1("l1 hs valid", rsp_valid_b, 1'b0);
        check1("l1 hs ready", req_ready_b, 1'b1);
        step();
        check1("l1 valid1", rsp_valid_b, 1'b1);
        check32("l1 data1", rsp_data_b, 32'h00400463);
        req_addr_b = 32'd5;
        step();
        check1("l1 hs2 valid", rsp_valid_b, 1'b0);
        step();
        check1("l1 valid2", rsp_valid_b, 1'b1);
        check1("l1 err2", rsp_err_b, 1'b1);
        check32("l1 data2", rsp_data_b, 32'h0);
        req_valid_b = 1'b0;
        step();
        check1("l1 end valid", rsp_valid_b, 1'b0);
        check1("l1 end busy", busy_b, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
